// File: rtl/rx_serial_7e1.sv
// 7E1 asynchronous serial receiver: start, 7 data bits LSB first, even parity, stop.
// Samples at bit centres and delivers each frame with a one-cycle pronto strobe.
module rx_serial_7e1 #(
    parameter int unsigned M = 434,
    parameter int unsigned N = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dados_serial,
    input  logic       recebe_dado,
    output logic [6:0] dados_ascii,
    output logic       pronto,
    output logic       tem_dado,
    output logic       erro_paridade,
    output logic       erro_parada,
    output logic       db_dados_serial,
    output logic       db_tick,
    output logic [3:0] db_estado
);

    typedef enum logic [3:0] {
        StRepouso       = 4'd0,
        StInicio        = 4'd1,
        StRecepcao      = 4'd2,
        StArmazena      = 4'd3,
        StEsperaRepouso = 4'd4
    } state_e;

    localparam logic [N-1:0] HalfLast = N'(M / 2 - 1);
    localparam logic [N-1:0] BitLast  = N'(M - 1);

    state_e       state_q, state_d;
    logic         sync1_q, sync2_q;
    logic [N-1:0] cnt_q, cnt_d;
    logic [3:0]   bit_q, bit_d;
    logic [8:0]   shift_q, shift_d;
    logic [6:0]   dados_q, dados_d;
    logic         pronto_q, pronto_d;
    logic         tem_dado_q, tem_dado_d;
    logic         erro_par_q, erro_par_d;
    logic         erro_stop_q, erro_stop_d;
    logic         s;
    logic         tick;
    logic         load;

    assign s = sync2_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        tick    = 1'b0;
        load    = 1'b0;
        case (state_q)
            StRepouso: begin
                cnt_d = '0;
                bit_d = '0;
                if (!s) state_d = StInicio;
            end
            StInicio: begin
                if (cnt_q == HalfLast) begin
                    tick    = 1'b1;
                    cnt_d   = '0;
                    state_d = s ? StRepouso : StRecepcao;
                end
            end
            StRecepcao: begin
                if (cnt_q == BitLast) begin
                    tick    = 1'b1;
                    cnt_d   = '0;
                    shift_d = {s, shift_q[8:1]};
                    bit_d   = bit_q + 4'd1;
                    // Ninth sample is the stop bit; results are registered on this edge
                    // so they are visible during the ARMAZENA cycle.
                    if (bit_q == 4'd8) begin
                        load    = 1'b1;
                        state_d = StArmazena;
                    end
                end
            end
            StArmazena: begin
                cnt_d   = '0;
                state_d = s ? StRepouso : StEsperaRepouso;
            end
            StEsperaRepouso: begin
                cnt_d = '0;
                if (s) state_d = StRepouso;
            end
            default: state_d = StRepouso;
        endcase
    end

    always_comb begin
        dados_d     = dados_q;
        erro_par_d  = erro_par_q;
        erro_stop_d = erro_stop_q;
        pronto_d    = load;
        tem_dado_d  = tem_dado_q;
        if (recebe_dado && state_q != StArmazena) tem_dado_d = 1'b0;
        if (load) begin
            dados_d     = shift_d[6:0];
            erro_par_d  = ^shift_d[7:0];
            erro_stop_d = ~shift_d[8];
            tem_dado_d  = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= StRepouso;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            dados_q     <= '0;
            pronto_q    <= 1'b0;
            tem_dado_q  <= 1'b0;
            erro_par_q  <= 1'b0;
            erro_stop_q <= 1'b0;
        end else begin
            sync1_q     <= dados_serial;
            sync2_q     <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            dados_q     <= dados_d;
            pronto_q    <= pronto_d;
            tem_dado_q  <= tem_dado_d;
            erro_par_q  <= erro_par_d;
            erro_stop_q <= erro_stop_d;
        end
    end

    assign dados_ascii     = dados_q;
    assign pronto          = pronto_q;
    assign tem_dado        = tem_dado_q;
    assign erro_paridade   = erro_par_q;
    assign erro_parada     = erro_stop_q;
    assign db_dados_serial = s;
    assign db_tick         = tick;
    assign db_estado       = state_q;

endmodule

// File: tb/tb_rx_serial_7e1.sv
// Directed bench for rx_serial_7e1: drives 7E1 frames and checks delivered characters,
// flags and timing against a queue of expected frames.
module tb_rx_serial_7e1;

    localparam int M = 434;
    localparam int N = 9;
    localparam int PRONTO_OFS = 2 + M / 2 + 9 * M + 1;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       dados_serial = 1'b1;
    logic       recebe_dado = 1'b0;
    logic [6:0] dados_ascii;
    logic       pronto;
    logic       tem_dado;
    logic       erro_paridade;
    logic       erro_parada;
    logic       db_dados_serial;
    logic       db_tick;
    logic [3:0] db_estado;

    rx_serial_7e1 #(.M(M), .N(N)) dut (
        .clock           (clock),
        .reset           (reset),
        .dados_serial    (dados_serial),
        .recebe_dado     (recebe_dado),
        .dados_ascii     (dados_ascii),
        .pronto          (pronto),
        .tem_dado        (tem_dado),
        .erro_paridade   (erro_paridade),
        .erro_parada     (erro_parada),
        .db_dados_serial (db_dados_serial),
        .db_tick         (db_tick),
        .db_estado       (db_estado)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] d;
        logic       perr;
        logic       serr;
        logic       tem;
        int         cyc;
    } frame_t;

    int     cyc = 0;
    frame_t obs_q[$];
    int     tick_q[$];
    frame_t exp_q[$];
    int     obs_rd = 0;
    int     n_checks = 0;
    int     n_fail = 0;

    always @(posedge clock) cyc <= cyc + 1;

    // Passive monitor: records every pronto strobe and every sample tick.
    always @(negedge clock) begin
        if (pronto === 1'b1)
            obs_q.push_back('{d: dados_ascii, perr: erro_paridade, serr: erro_parada,
                              tem: tem_dado, cyc: cyc});
        if (db_tick === 1'b1) tick_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic next_drive();
        @(posedge clock);
        #1;
    endtask

    task automatic hold_bit(input logic b);
        dados_serial = b;
        repeat (M) @(posedge clock);
        #1;
    endtask

    // Called at posedge+1; returns with the line left at the stop-bit value.
    task automatic send_frame(input logic [6:0] ch, input logic bad_par, input logic stop,
                              output int start_cyc);
        logic p;
        p = (^ch) ^ bad_par;
        start_cyc = cyc;
        exp_q.push_back('{d: ch, perr: bad_par, serr: ~stop, tem: 1'b1,
                          cyc: start_cyc + PRONTO_OFS});
        hold_bit(1'b0);
        for (int i = 0; i < 7; i++) hold_bit(ch[i]);
        hold_bit(p);
        hold_bit(stop);
    endtask

    task automatic check_frame(input string tag);
        frame_t e, o;
        int pending;
        pending = obs_q.size() - obs_rd;
        e = exp_q.pop_front();
        chk({tag, "_pronto_count"}, pending, 1);
        if (pending >= 1) begin
            o = obs_q[obs_rd];
            chk({tag, "_data"}, o.d, e.d);
            chk({tag, "_erro_paridade"}, o.perr, e.perr);
            chk({tag, "_erro_parada"}, o.serr, e.serr);
            chk({tag, "_tem_dado"}, o.tem, e.tem);
            chk({tag, "_pronto_cycle"}, o.cyc, e.cyc);
        end
        obs_rd = obs_q.size();
    endtask

    initial begin
        int st;
        int tick_base;
        int nt;

        repeat (3) next_drive();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_dados_ascii", dados_ascii, 7'h00);
        chk("rst_pronto", pronto, 1'b0);
        chk("rst_tem_dado", tem_dado, 1'b0);
        chk("rst_erro_paridade", erro_paridade, 1'b0);
        chk("rst_erro_parada", erro_parada, 1'b0);
        chk("rst_db_tick", db_tick, 1'b0);
        chk("rst_db_estado", db_estado, 4'd0);
        chk("rst_db_dados_serial", db_dados_serial, 1'b1);
        next_drive();

        // Basic frame with tick timing
        tick_base = tick_q.size();
        send_frame(7'h41, 1'b0, 1'b1, st);
        check_frame("basic");
        nt = tick_q.size() - tick_base;
        chk("basic_tick_count", nt, 10);
        for (int i = 0; i < nt && i < 10; i++)
            chk("basic_tick_cycle", tick_q[tick_base + i], st + 2 + M / 2 + i * M);
        @(negedge clock);
        chk("basic_tem_dado_held", tem_dado, 1'b1);
        next_drive();

        // Parity error
        send_frame(7'h41, 1'b1, 1'b1, st);
        check_frame("parity");

        // Framing error followed by a break
        send_frame(7'h55, 1'b0, 1'b0, st);
        check_frame("framing");
        repeat (1000) @(posedge clock);
        @(negedge clock);
        chk("break_estado", db_estado, 4'd4);
        chk("break_erro_parada", erro_parada, 1'b1);
        next_drive();
        repeat (1000) @(posedge clock);
        #1;
        dados_serial = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("break_end_estado", db_estado, 4'd0);
        chk("break_no_second_frame", obs_q.size() - obs_rd, 0);
        next_drive();
        send_frame(7'h2A, 1'b0, 1'b1, st);
        check_frame("after_break");

        // False start glitch
        dados_serial = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        dados_serial = 1'b1;
        repeat (500) @(posedge clock);
        @(negedge clock);
        chk("glitch_estado", db_estado, 4'd0);
        chk("glitch_no_pronto", obs_q.size() - obs_rd, 0);
        chk("glitch_dados_kept", dados_ascii, 7'h2A);
        chk("glitch_tem_dado_kept", tem_dado, 1'b1);
        next_drive();

        // Handshake, redundant acknowledge, overrun
        send_frame(7'h31, 1'b0, 1'b1, st);
        check_frame("hs_31");
        recebe_dado = 1'b1;
        next_drive();
        recebe_dado = 1'b0;
        @(negedge clock);
        chk("hs_ack_clears", tem_dado, 1'b0);
        next_drive();
        recebe_dado = 1'b1;
        next_drive();
        recebe_dado = 1'b0;
        @(negedge clock);
        chk("hs_ack_idle_tem", tem_dado, 1'b0);
        chk("hs_ack_idle_data", dados_ascii, 7'h31);
        next_drive();
        send_frame(7'h32, 1'b0, 1'b1, st);
        check_frame("ovr_32");
        send_frame(7'h33, 1'b0, 1'b1, st);
        check_frame("ovr_33");
        @(negedge clock);
        chk("ovr_data", dados_ascii, 7'h33);
        chk("ovr_tem_dado", tem_dado, 1'b1);
        next_drive();

        // Acknowledge coincident with the ARMAZENA cycle
        fork
            send_frame(7'h34, 1'b0, 1'b1, st);
            begin
                repeat (PRONTO_OFS) @(posedge clock);
                #1;
                recebe_dado = 1'b1;
                @(posedge clock);
                #1;
                recebe_dado = 1'b0;
            end
        join
        check_frame("simul_34");
        @(negedge clock);
        chk("simul_tem_dado", tem_dado, 1'b1);
        next_drive();

        // Reset after the fourth data bit of 0x5A
        hold_bit(1'b0);
        for (int i = 0; i < 4; i++) hold_bit(i[0] ? 1'b1 : 1'b0);
        dados_serial = 1'b1;
        reset = 1'b1;
        next_drive();
        reset = 1'b0;
        @(negedge clock);
        chk("midrst_estado", db_estado, 4'd0);
        chk("midrst_dados", dados_ascii, 7'h00);
        chk("midrst_tem_dado", tem_dado, 1'b0);
        chk("midrst_pronto", pronto, 1'b0);
        chk("midrst_erros", {erro_paridade, erro_parada}, 2'b00);
        next_drive();
        repeat (6 * M) @(posedge clock);
        #1;
        chk("midrst_no_pronto", obs_q.size() - obs_rd, 0);
        send_frame(7'h7E, 1'b0, 1'b1, st);
        check_frame("after_rst_7e");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rx_serial_7e1.md
# rx_serial_7E1

Asynchronous serial receiver for 7E1 frames: 1 start bit, 7 data bits LSB first, even parity, stop bit. It is the receive-side counterpart of the serial transmitter. It samples the incoming line at bit centres, checks parity and stop bit, and presents the received ASCII character with a one-cycle `pronto` strobe and a sticky `tem_dado` flag. It sits between the board's serial RX pin and the character-consuming logic, at 115200 baud from a 50 MHz clock by default.

## Interface
- `M`, 434: clock cycles per bit (50M/115200); 5208 for 9600 baud
- `N`, 9: width of the bit-timing counter; must satisfy 2^N > M
- `clock` in 1: system clock, all logic on the rising edge
- `reset` in 1: synchronous, active-high; clears all state and outputs
- `dados_serial` in 1: serial line, idle high, asynchronous to `clock`
- `recebe_dado` in 1: consumer acknowledge; a 1-cycle pulse clears `tem_dado`
- `dados_ascii` out 7: last received character
- `pronto` out 1: 1-cycle pulse when a frame completes
- `tem_dado` out 1: a character is held and has not yet been acknowledged
- `erro_paridade` out 1: last frame failed even parity
- `erro_parada` out 1: last frame had stop bit = 0
- `db_dados_serial` out 1: synchronized line value
- `db_tick` out 1: 1-cycle strobe at every sample instant
- `db_estado` out 4: current FSM state code

## Operation
- Input path: 2-flop synchronizer on `dados_serial`. All logic uses the synchronized value `s`.
- FSM states and `db_estado` codes:
  - REPOUSO (0): wait for `s`=0. The first cycle with `s`=0 is t0. The bit counter is zeroed at t0, and the FSM goes to INICIO.
  - INICIO (1): at cycle t0+floor(M/2), sample the start bit.
    - `s`=1: false start. Return to REPOUSO, with no outputs changed.
    - `s`=0: go to RECEPCAO, zero the counter.
  - RECEPCAO (2): sample at t0+floor(M/2)+k·M for k=1..9.
    - k=1..7: data bits d0..d6, shifted into a 9-bit shift register.
    - k=8: parity bit.
    - k=9: stop bit.
    - After k=9, go to ARMAZENA.
  - ARMAZENA (3): one cycle.
    - Load `dados_ascii`.
    - Set `erro_paridade` = XOR of the 7 data bits and the parity bit.
    - Set `erro_parada` = NOT stop bit.
    - Pulse `pronto`; set `tem_dado`=1.
    - Next state: REPOUSO if `s`=1, otherwise ESPERA_REPOUSO.
  - ESPERA_REPOUSO (4): wait for `s`=1 (line break or framing error), then go to REPOUSO. A new start is never detected before the line returns high.
- `db_tick` pulses in the same cycle as each of the 10 samples (start, data, parity, stop).
- A frame with errors is still delivered: data is loaded, `pronto` pulses, `tem_dado` is set, and the error flags are raised.
- Error flags and `dados_ascii` hold until the next ARMAZENA or `reset`.
- `tem_dado` is cleared by `recebe_dado`=1 in any cycle other than ARMAZENA.
- Boundary rules:
  - **Overrun:** a frame completes while `tem_dado`=1. New data overwrites the old and `tem_dado` stays 1.
  - **Simultaneous events:** `recebe_dado` and ARMAZENA in the same cycle. ARMAZENA wins and `tem_dado`=1 afterwards.
  - **`recebe_dado` with `tem_dado`=0:** no effect.
  - **`reset` mid-frame:** next cycle state is REPOUSO and all outputs are 0. The partial frame is discarded and `pronto` never pulses for it.
  - **Unused state codes:** recover to REPOUSO.

## Timing
- Reset values (after a `reset` cycle):
  - `dados_ascii`=0, `pronto`=0, `tem_dado`=0
  - `erro_paridade`=0, `erro_parada`=0
  - `db_tick`=0, `db_estado`=0
  - synchronizer flops = 1
- Line-to-`s` latency: 2 cycles.
- Sample instants relative to t0: floor(M/2)+k·M, k=0..9. With M=434 these are 217, 651, …, 4123.
- `pronto` and the updated outputs appear at t0+floor(M/2)+9M+1, which is t0+4124 for M=434. They are registered and glitch-free.
- Minimum spacing between back-to-back frames: the next falling edge may occur any time after the stop-bit sample. A second stop bit is accepted as idle.

## Test plan
- **Basic frame:** reset, then send `'A'` (0x41, parity 0, stop 1) at M=434 cycles/bit. Required response:
  - `pronto` pulses exactly once at t0+4124
  - `dados_ascii`=0x41, `tem_dado`=1
  - `erro_paridade`=0, `erro_parada`=0
  - `db_tick` pulses 10 times, 434 cycles apart
- **Parity error:** send 0x41 with the parity bit set to 1. Required: `dados_ascii`=0x41, `erro_paridade`=1, `pronto` pulses, `tem_dado`=1.
- **Framing error and break:**
  - Send 0x55 with stop bit = 0, then hold the line low for 2000 cycles. Required: `erro_parada`=1, `db_estado`=4 until the line goes high, and no second frame detected.
  - Then send 0x2A. Required: `dados_ascii`=0x2A, `erro_parada`=0.
- **False start:** drive a 100-cycle low glitch. Required: return to REPOUSO, no `pronto`, outputs unchanged.
- **Handshake and overrun:**
  - Receive 0x31, then pulse `recebe_dado`. Required: `tem_dado`=0.
  - Receive 0x32 and 0x33 without acknowledge. Required: `dados_ascii`=0x33, `tem_dado`=1.
  - Assert `recebe_dado` in the ARMAZENA cycle. Required: `tem_dado` remains 1.
- **Reset mid-frame:** assert `reset` for 1 cycle after the 4th data bit. Required: `db_estado`=0, all outputs 0, no `pronto` for that frame. The next full frame 0x7E is received correctly.
